sdram_refresh_sequencer: RTL and testbench

Consumer of the refresh-due handshake produced by `auto_refresh_counter`. When the counter raises `request`, this block:

- obtains the SDRAM command bus from the main controller arbiter;
- issues PRECHARGE ALL followed by a configurable burst of AUTO REFRESH commands, honouring tRP and tRFC;
- returns the bus and pulses `response` back to the counter.

It sits between `auto_refresh_counter` and the SDRAM command multiplexer.

---
 rtl/sdram_refresh_sequencer.sv | 163 ++++++++++++++++
 tb/tb_sdram_refresh_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_refresh_sequencer.sv
// Refresh sequencer: acquires the SDRAM command bus, issues PRECHARGE ALL plus
// a burst of AUTO REFRESH commands with tRP/tRFC spacing, then acks the counter.
module sdram_refresh_sequencer #(
  parameter int T_RP_CYCLES   = 2,
  parameter int T_RFC_CYCLES  = 7,
  parameter int REFRESH_BURST = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic refresh_request,
  output logic refresh_response,
  output logic bus_request,
  input  logic bus_grant,
  output logic sdram_cs_n,
  output logic sdram_ras_n,
  output logic sdram_cas_n,
  output logic sdram_we_n,
  output logic sdram_a10,
  output logic busy
);

  localparam int CNT_MAX = (T_RP_CYCLES > T_RFC_CYCLES) ? T_RP_CYCLES : T_RFC_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int BURST_W = $clog2(REFRESH_BURST) + 1;

  localparam logic [CNT_W-1:0]   RP_LOAD  = CNT_W'(T_RP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RFC_LOAD = CNT_W'(T_RFC_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_N  = BURST_W'(REFRESH_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GRANT,
    S_PRECHARGE,
    S_WAIT_RP,
    S_REFRESH,
    S_WAIT_RFC,
    S_DONE,
    S_COOLDOWN
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BURST_W-1:0] r_burst;
  logic [3:0]         r_cmd;
  logic               r_a10;
  logic               r_bus_req;
  logic               r_resp;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BURST_W-1:0] w_burst_nxt;
  logic [3:0]         w_cmd_nxt;
  logic               w_a10_nxt;
  logic               w_bus_req_nxt;
  logic               w_resp_nxt;
  logic               w_busy_nxt;

  // After a refresh (and its tRFC) either another refresh follows or the burst is complete.
  function automatic state_t f_after_refresh(input logic [BURST_W-1:0] issued);
    return (issued < BURST_N) ? S_REFRESH : S_DONE;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_burst_nxt = r_burst;
    case (r_state)
      S_IDLE: begin
        if (refresh_request) w_state_nxt = S_WAIT_GRANT;
      end
      S_WAIT_GRANT: begin
        if (bus_grant) w_state_nxt = S_PRECHARGE;
      end
      S_PRECHARGE: begin
        w_cnt_nxt   = RP_LOAD;
        w_state_nxt = (RP_LOAD == '0) ? S_REFRESH : S_WAIT_RP;
      end
      S_WAIT_RP: begin
        w_cnt_nxt = (r_cnt != '0) ? r_cnt - CNT_ONE : '0;
        if (r_cnt <= CNT_ONE) w_state_nxt = S_REFRESH;
      end
      S_REFRESH: begin
        w_burst_nxt = r_burst + BURST_ONE;
        w_cnt_nxt   = RFC_LOAD;
        w_state_nxt = (RFC_LOAD == '0) ? f_after_refresh(w_burst_nxt) : S_WAIT_RFC;
      end
      S_WAIT_RFC: begin
        w_cnt_nxt = (r_cnt != '0) ? r_cnt - CNT_ONE : '0;
        if (r_cnt <= CNT_ONE) w_state_nxt = f_after_refresh(r_burst);
      end
      S_DONE: begin
        w_burst_nxt = '0;
        w_state_nxt = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pins show each state's command during that state.
  always_comb begin
    w_cmd_nxt     = CMD_NOP;
    w_a10_nxt     = 1'b0;
    w_bus_req_nxt = 1'b0;
    w_resp_nxt    = 1'b0;
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_WAIT_GRANT, S_WAIT_RP, S_WAIT_RFC: w_bus_req_nxt = 1'b1;
      S_PRECHARGE: begin
        w_cmd_nxt     = CMD_PRE;
        w_a10_nxt     = 1'b1;
        w_bus_req_nxt = 1'b1;
      end
      S_REFRESH: begin
        w_cmd_nxt     = CMD_REF;
        w_bus_req_nxt = 1'b1;
      end
      S_DONE: w_resp_nxt = 1'b1;
      default: w_cmd_nxt = CMD_NOP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_cmd     <= CMD_NOP;
      r_a10     <= 1'b0;
      r_bus_req <= 1'b0;
      r_resp    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_burst   <= w_burst_nxt;
      r_cmd     <= w_cmd_nxt;
      r_a10     <= w_a10_nxt;
      r_bus_req <= w_bus_req_nxt;
      r_resp    <= w_resp_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cmd;
  assign sdram_a10        = r_a10;
  assign bus_request      = r_bus_req;
  assign refresh_response = r_resp;
  assign busy             = r_busy;

endmodule

// File: tb/tb_sdram_refresh_sequencer.sv
// Bench for sdram_refresh_sequencer: three parameterisations checked against a
// timeline model (expected pins as a function of cycles since the grant).
module tb_sdram_refresh_sequencer;

  localparam int N = 3;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [7:0] V_IDLE  = 8'b0111_0000;
  localparam logic [7:0] V_WAIT  = 8'b0111_0101;

  function automatic int p_rp(input int i);
    return (i == 2) ? 1 : 2;
  endfunction
  function automatic int p_rfc(input int i);
    return (i == 2) ? 1 : 7;
  endfunction
  function automatic int p_b(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] hold;
  logic [N-1:0] noise;
  logic [N-1:0] w_resp, w_breq, w_cs, w_ras, w_cas, w_we, w_a10, w_busy;
  logic [7:0]   obs  [N];
  logic [7:0]   expv [N];

  int go_seq   [N] = '{0, 0, 0};
  int drop_seq [N] = '{0, 0, 0};
  int rise_cyc [N] = '{0, 0, 0};
  int mode     [N] = '{0, 0, 0};
  int t0       [N] = '{0, 0, 0};
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  sdram_refresh_sequencer u_def (
    .clock(clock), .reset(reset), .refresh_request(req[0]), .refresh_response(w_resp[0]),
    .bus_request(w_breq[0]), .bus_grant(grant[0]), .sdram_cs_n(w_cs[0]), .sdram_ras_n(w_ras[0]),
    .sdram_cas_n(w_cas[0]), .sdram_we_n(w_we[0]), .sdram_a10(w_a10[0]), .busy(w_busy[0]));

  sdram_refresh_sequencer #(.T_RP_CYCLES(2), .T_RFC_CYCLES(7), .REFRESH_BURST(2)) u_burst (
    .clock(clock), .reset(reset), .refresh_request(req[1]), .refresh_response(w_resp[1]),
    .bus_request(w_breq[1]), .bus_grant(grant[1]), .sdram_cs_n(w_cs[1]), .sdram_ras_n(w_ras[1]),
    .sdram_cas_n(w_cas[1]), .sdram_we_n(w_we[1]), .sdram_a10(w_a10[1]), .busy(w_busy[1]));

  sdram_refresh_sequencer #(.T_RP_CYCLES(1), .T_RFC_CYCLES(1), .REFRESH_BURST(1)) u_fast (
    .clock(clock), .reset(reset), .refresh_request(req[2]), .refresh_response(w_resp[2]),
    .bus_request(w_breq[2]), .bus_grant(grant[2]), .sdram_cs_n(w_cs[2]), .sdram_ras_n(w_ras[2]),
    .sdram_cas_n(w_cas[2]), .sdram_we_n(w_we[2]), .sdram_a10(w_a10[2]), .busy(w_busy[2]));

  for (genvar g = 0; g < N; g++) begin : g_obs
    assign obs[g] = {w_cs[g], w_ras[g], w_cas[g], w_we[g], w_a10[g], w_breq[g], w_resp[g], w_busy[g]};
  end

  // Reference model plus grant generator (grant = bus_request delayed one cycle unless held/noisy).
  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      int L;
      int o;
      int k;
      logic [3:0] cmd;
      L = 1 + p_rp(i) + p_b(i) * p_rfc(i);
      if (reset) mode[i] = 0;
      else if (mode[i] == 0) begin
        if (req[i]) mode[i] = 1;
      end else if (mode[i] == 1) begin
        if (grant[i]) begin
          mode[i] = 2;
          t0[i] = cyc;
        end
      end else if (cyc - t0[i] == L + 1) mode[i] = 0;
      o = cyc - t0[i] + 1;
      k = o - 1 - p_rp(i);
      if (mode[i] == 0) expv[i] = V_IDLE;
      else if (mode[i] == 1) expv[i] = V_WAIT;
      else begin
        cmd = 4'b0111;
        if (o == 1) cmd = CMD_PRE;
        else if (k >= 0 && (k % p_rfc(i)) == 0 && (k / p_rfc(i)) < p_b(i)) cmd = CMD_REF;
        expv[i] = {cmd, (o == 1), (o < L), (o == L), 1'b1};
      end
      grant[i] <= hold[i] ? 1'b0 : (noise[i] ? 1'($urandom_range(0, 1)) : w_breq[i]);
    end
  end

  // Request driver: raise on demand, hold through DONE and COOLDOWN, drop in the following cycle.
  initial begin
    int seen_go [N];
    int seen_dr [N];
    int rel     [N];
    req = '0;
    for (int i = 0; i < N; i++) begin
      seen_go[i] = 0;
      seen_dr[i] = 0;
      rel[i] = 0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (go_seq[i] != seen_go[i]) begin
          seen_go[i] = go_seq[i];
          req[i] = 1'b1;
          rel[i] = 0;
          rise_cyc[i] = cyc;
        end else if (drop_seq[i] != seen_dr[i]) begin
          seen_dr[i] = drop_seq[i];
          req[i] = 1'b0;
          rel[i] = 0;
        end else if (rel[i] > 0) begin
          rel[i] = rel[i] - 1;
          if (rel[i] == 0) req[i] = 1'b0;
        end else if (req[i] && expv[i][1]) rel[i] = 2;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs[i] !== V_IDLE) begin
        errors++;
        $display("FAIL reset_values inst%0d: got %b expected %b", i, obs[i], V_IDLE);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_default_sequence();
    int pc_n = 0, rf_n = 0, a10_n = 0, a10_bad = 0;
    int t_breq = -1, t_pc = -1, t_rf = -1, t_rsp = -1, t_low = -1;
    go_seq[0]++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (obs[i] !== expv[i]) begin
          errors++;
          $display("FAIL default_model inst%0d cyc%0d: got %b expected %b", i, cyc, obs[i], expv[i]);
        end
      end
      if (obs[0][7:4] == CMD_PRE) begin pc_n++; t_pc = cyc - rise_cyc[0]; end
      if (obs[0][7:4] == CMD_REF) begin rf_n++; t_rf = cyc - rise_cyc[0]; end
      if (obs[0][3]) a10_n++;
      if (obs[0][3] && obs[0][7:4] != CMD_PRE) a10_bad++;
      if (obs[0][1]) t_rsp = cyc - rise_cyc[0];
      if (obs[0][2] && t_breq < 0) t_breq = cyc - rise_cyc[0];
      if (!obs[0][2] && t_breq >= 0 && t_low < 0) t_low = cyc - rise_cyc[0];
    end
    checks++; if (t_breq != 1)  begin errors++; $display("FAIL default_breq_latency: got %0d expected 1", t_breq); end
    checks++; if (t_pc != 3)    begin errors++; $display("FAIL default_precharge_time: got %0d expected 3", t_pc); end
    checks++; if (t_rf != 5)    begin errors++; $display("FAIL default_refresh_time: got %0d expected 5", t_rf); end
    checks++; if (t_rsp != 12)  begin errors++; $display("FAIL default_response_time: got %0d expected 12", t_rsp); end
    checks++; if (t_low != 12)  begin errors++; $display("FAIL default_breq_low_time: got %0d expected 12", t_low); end
    checks++; if (pc_n != 1)    begin errors++; $display("FAIL default_precharge_count: got %0d expected 1", pc_n); end
    checks++; if (rf_n != 1)    begin errors++; $display("FAIL default_refresh_count: got %0d expected 1", rf_n); end
    checks++; if (a10_n != 1 || a10_bad != 0) begin
      errors++; $display("FAIL default_a10: high %0d cycles (%0d outside precharge) expected 1 (0)", a10_n, a10_bad);
    end
  endtask

  task automatic test_burst();
    int rf_n = 0, t_rf1 = -1, t_rf2 = -1, t_rsp = -1;
    go_seq[1]++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (obs[i] !== expv[i]) begin
          errors++;
          $display("FAIL burst_model inst%0d cyc%0d: got %b expected %b", i, cyc, obs[i], expv[i]);
        end
      end
      if (obs[1][7:4] == CMD_REF) begin
        rf_n++;
        if (t_rf1 < 0) t_rf1 = cyc - rise_cyc[1];
        else t_rf2 = cyc - rise_cyc[1];
      end
      if (obs[1][1]) t_rsp = cyc - rise_cyc[1];
    end
    checks++; if (t_rf1 != 5)  begin errors++; $display("FAIL burst_refresh0_time: got %0d expected 5", t_rf1); end
    checks++; if (t_rf2 != 12) begin errors++; $display("FAIL burst_refresh1_time: got %0d expected 12", t_rf2); end
    checks++; if (t_rsp != 19) begin errors++; $display("FAIL burst_response_time: got %0d expected 19", t_rsp); end
    checks++; if (rf_n != 2)   begin errors++; $display("FAIL burst_refresh_count: got %0d expected 2", rf_n); end
  endtask

  task automatic test_min_timing();
    int t_pc = -1, t_rf = -1, t_rsp = -1;
    go_seq[2]++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (obs[i] !== expv[i]) begin
          errors++;
          $display("FAIL min_model inst%0d cyc%0d: got %b expected %b", i, cyc, obs[i], expv[i]);
        end
      end
      if (obs[2][7:4] == CMD_PRE) t_pc = cyc - rise_cyc[2];
      if (obs[2][7:4] == CMD_REF) t_rf = cyc - rise_cyc[2];
      if (obs[2][1]) t_rsp = cyc - rise_cyc[2];
    end
    checks++; if (t_pc != 3)  begin errors++; $display("FAIL min_precharge_time: got %0d expected 3", t_pc); end
    checks++; if (t_rf != 4)  begin errors++; $display("FAIL min_refresh_time: got %0d expected 4", t_rf); end
    checks++; if (t_rsp != 5) begin errors++; $display("FAIL min_response_time: got %0d expected 5", t_rsp); end
  endtask

  task automatic test_grant_withheld();
    int pc_early = 0, pc_late = 0, not_wait = 0;
    hold[0] = 1'b1;
    go_seq[0]++;
    for (int c = 0; c < 52; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (obs[i] !== expv[i]) begin
          errors++;
          $display("FAIL withheld_model inst%0d cyc%0d: got %b expected %b", i, cyc, obs[i], expv[i]);
        end
      end
      if (obs[0][7:4] == CMD_PRE) pc_early++;
      if (c >= 2 && obs[0] !== V_WAIT) not_wait++;
    end
    checks++; if (pc_early != 0 || not_wait != 0) begin
      errors++; $display("FAIL withheld_wait: %0d precharges, %0d non-wait cycles, expected 0 and 0", pc_early, not_wait);
    end
    hold[0] = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      checks++;
      if (obs[0] !== expv[0]) begin
        errors++;
        $display("FAIL withheld_release_model cyc%0d: got %b expected %b", cyc, obs[0], expv[0]);
      end
      if (obs[0][7:4] == CMD_PRE) pc_late++;
    end
    checks++; if (pc_late != 1) begin errors++; $display("FAIL withheld_precharge_count: got %0d expected 1", pc_late); end
  endtask

  task automatic test_cooldown_rerequest();
    int t_pc [2] = '{-1, -1};
    int t_rsp [2] = '{-1, -1};
    int breq_idle = 0;
    for (int s = 0; s < 2; s++) begin
      go_seq[0]++;
      for (int c = 0; c < 30; c++) begin
        @(negedge clock);
        checks++;
        if (obs[0] !== expv[0]) begin
          errors++;
          $display("FAIL cooldown_model seq%0d cyc%0d: got %b expected %b", s, cyc, obs[0], expv[0]);
        end
        if (obs[0][7:4] == CMD_PRE) t_pc[s] = cyc - rise_cyc[0];
        if (obs[0][1]) t_rsp[s] = cyc - rise_cyc[0];
      end
      if (s == 0) begin
        for (int c = 0; c < 100; c++) begin
          @(negedge clock);
          if (obs[0][2] || obs[0][0]) breq_idle++;
        end
        checks++;
        if (breq_idle != 0) begin errors++; $display("FAIL cooldown_no_rerequest: %0d busy cycles, expected 0", breq_idle); end
      end
    end
    checks++; if (t_pc[1] != t_pc[0] || t_pc[0] != 3) begin
      errors++; $display("FAIL rerequest_precharge: got %0d and %0d expected 3 and 3", t_pc[0], t_pc[1]);
    end
    checks++; if (t_rsp[1] != t_rsp[0] || t_rsp[0] != 12) begin
      errors++; $display("FAIL rerequest_response: got %0d and %0d expected 12 and 12", t_rsp[0], t_rsp[1]);
    end
  endtask

  task automatic test_reset_mid();
    int found = 0, rsp_n = 0;
    go_seq[0]++;
    for (int c = 0; c < 30 && found == 0; c++) begin
      @(negedge clock);
      checks++;
      if (obs[0] !== expv[0]) begin
        errors++;
        $display("FAIL reset_mid_model cyc%0d: got %b expected %b", cyc, obs[0], expv[0]);
      end
      if (obs[0][7:4] == CMD_REF) found = 1;
    end
    checks++; if (found == 0) begin errors++; $display("FAIL reset_mid_refresh_seen: got 0 expected 1 (timeout)"); end
    @(negedge clock);
    reset = 1'b1;
    drop_seq[0]++;
    @(negedge clock);
    checks++;
    if (obs[0] !== V_IDLE) begin errors++; $display("FAIL reset_mid_abort: got %b expected %b", obs[0], V_IDLE); end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      checks++;
      if (obs[0] !== expv[0]) begin
        errors++;
        $display("FAIL reset_mid_after cyc%0d: got %b expected %b", cyc, obs[0], expv[0]);
      end
      if (obs[0][1]) rsp_n++;
    end
    checks++; if (rsp_n != 0) begin errors++; $display("FAIL reset_mid_no_response: got %0d pulses expected 0", rsp_n); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int i, rel_at, early;
      i = $urandom_range(0, N - 1);
      hold[i]  = 1'($urandom_range(0, 1));
      noise[i] = 1'($urandom_range(0, 1));
      rel_at = $urandom_range(0, 20);
      early  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      go_seq[i]++;
      for (int c = 0; c < 60; c++) begin
        @(negedge clock);
        for (int j = 0; j < N; j++) begin
          checks++;
          if (obs[j] !== expv[j]) begin
            errors++;
            $display("FAIL random_model it%0d inst%0d cyc%0d: got %b expected %b", it, j, cyc, obs[j], expv[j]);
          end
        end
        if (c == rel_at) hold[i] = 1'b0;
        if (early == 1 && c == 2 && mode[i] == 1) drop_seq[i]++;
      end
      hold[i]  = 1'b0;
      noise[i] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    hold  = '0;
    noise = '0;
    test_reset();
    test_default_sequence();
    test_burst();
    test_min_timing();
    test_grant_withheld();
    test_cooldown_rerequest();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
